cond_unit: RTL and testbench

Condition unit for the multicycle ARM datapath: the consumer of the ALU's `{Neg, Zero, Carry, Overflow}` flag vector. It holds the architectural NZCV flags register and evaluates the instruction's 4-bit condition field against the stored flags. It latches the resulting execute decision for the rest of the instruction and gates the controller's PC, register-file, memory and flag write strobes. It sits between the main control FSM/decoder and the datapath write enables.

---
 rtl/cond_unit.sv | 70 +++++++
 tb/tb_cond_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register, condition evaluation and
// execute-gated PC/register/memory write strobes.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic n, z, c, v;
  logic ge;
  logic cond_ok;

  assign {n, z, c, v} = Flags;
  assign ge = (n == v);

  // Always evaluated on the stored flags, never the live ALU flags.
  always_comb begin
    cond_ok = 1'b0;
    unique case (Cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = ge;
      4'b1011: cond_ok = ~ge;
      4'b1100: cond_ok = ~z & ge;
      4'b1101: cond_ok = z | ~ge;
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = 1'b0;
    endcase
  end

  // Flag halves are gated by the execute decision held before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags  <= 4'b0000;
      CondEx <= 1'b0;
    end else begin
      if (CondLatch)
        CondEx <= cond_ok;
      if (FlagW[1] & CondEx)
        Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & CondEx)
        Flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite  = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios plus random stimulus
// checked every cycle against a behavioural flag/condition model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  int tests = 0;
  int fails = 0;

  logic [3:0] m_flags;
  logic       m_ex;
  logic       chk_en = 1'b0;

  cond_unit dut (
    .clk(clk),
    .reset(reset),
    .Cond(Cond),
    .ALUFlags(ALUFlags),
    .FlagW(FlagW),
    .CondLatch(CondLatch),
    .PCS(PCS),
    .RegW(RegW),
    .MemW(MemW),
    .NoWrite(NoWrite),
    .Flags(Flags),
    .CondEx(CondEx),
    .PCWrite(PCWrite),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite)
  );

  always #5 clk = ~clk;

  // Even codes test a base predicate, odd codes its inverse; 1110/1111 are fixed.
  function automatic logic cond_ref(input logic [3:0] cd, input logic [3:0] fl);
    logic fn, fz, fc, fv, b;
    {fn, fz, fc, fv} = fl;
    b = 1'b0;
    case (cd[3:1])
      3'd0: b = fz;
      3'd1: b = fc;
      3'd2: b = fn;
      3'd3: b = fv;
      3'd4: b = fc && !fz;
      3'd5: b = (fn == fv);
      3'd6: b = !fz && (fn == fv);
      default: return (cd == 4'b1110);
    endcase
    return b ^ cd[0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags <= 4'b0000;
      m_ex    <= 1'b0;
    end else begin
      if (CondLatch)
        m_ex <= cond_ref(Cond, m_flags);
      m_flags <= {(FlagW[1] && m_ex) ? ALUFlags[3:2] : m_flags[3:2],
                  (FlagW[0] && m_ex) ? ALUFlags[1:0] : m_flags[1:0]};
    end
  end

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model Flags", Flags, m_flags);
      check("model CondEx", {3'b0, CondEx}, {3'b0, m_ex});
      check("model PCWrite", {3'b0, PCWrite}, {3'b0, PCS && m_ex});
      check("model RegWrite", {3'b0, RegWrite},
            {3'b0, RegW && m_ex && !NoWrite});
      check("model MemWrite", {3'b0, MemWrite}, {3'b0, MemW && m_ex});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [3:0] cd);
    Cond = cd;
    CondLatch = 1'b1;
    step();
    CondLatch = 1'b0;
  endtask

  task automatic write_flags(input logic [1:0] fw, input logic [3:0] af);
    FlagW = fw;
    ALUFlags = af;
    step();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b0;
    Cond = 4'h0;
    ALUFlags = 4'h0;
    FlagW = 2'b00;
    CondLatch = 1'b0;
    PCS = 1'b1;
    RegW = 1'b1;
    MemW = 1'b1;
    NoWrite = 1'b0;

    // Model pins
    check("pin GE 1001", {3'b0, cond_ref(4'hA, 4'h9)}, 4'd1);
    check("pin LT 1001", {3'b0, cond_ref(4'hB, 4'h9)}, 4'd0);
    check("pin HI 0010", {3'b0, cond_ref(4'h8, 4'h2)}, 4'd1);
    check("pin LS 0110", {3'b0, cond_ref(4'h9, 4'h6)}, 4'd1);
    check("pin NV 1111", {3'b0, cond_ref(4'hF, 4'hF)}, 4'd0);
    check("pin GT 0000", {3'b0, cond_ref(4'hC, 4'h0)}, 4'd1);
    check("pin LE 0100", {3'b0, cond_ref(4'hD, 4'h4)}, 4'd1);

    #3;
    check("reset Flags", Flags, 4'b0000);
    check("reset CondEx", {3'b0, CondEx}, 4'd0);
    check("reset strobes", {1'b0, PCWrite, RegWrite, MemWrite}, 4'b0000);
    step();
    reset = 1'b1;
    chk_en = 1'b1;
    step();
    check("release holds CondEx", {3'b0, CondEx}, 4'd0);

    latch(4'hE);
    check("AL CondEx", {3'b0, CondEx}, 4'd1);
    check("AL PCWrite", {3'b0, PCWrite}, 4'd1);

    write_flags(2'b11, 4'b0100);
    check("CMP Flags", Flags, 4'b0100);
    latch(4'h0);
    check("EQ PCWrite", {3'b0, PCWrite}, 4'd1);
    latch(4'h1);
    check("NE CondEx", {3'b0, CondEx}, 4'd0);
    check("NE PCWrite", {3'b0, PCWrite}, 4'd0);

    write_flags(2'b11, 4'b1111);
    check("suppressed Flags", Flags, 4'b0100);
    check("suppressed MemWrite", {3'b0, MemWrite}, 4'd0);

    latch(4'hE);
    write_flags(2'b11, 4'b1001);
    check("setup Flags", Flags, 4'b1001);
    write_flags(2'b10, 4'b0110);
    check("partial Flags", Flags, 4'b0101);

    for (int f = 0; f < 16; f++) begin
      latch(4'hE);
      write_flags(2'b11, 4'(f));
      for (int cd = 0; cd < 16; cd++) begin
        latch(4'(cd));
        check("sweep CondEx", {3'b0, CondEx},
              {3'b0, cond_ref(4'(cd), 4'(f))});
      end
    end

    latch(4'hE);
    RegW = 1'b1;
    NoWrite = 1'b1;
    #1;
    check("NoWrite RegWrite", {3'b0, RegWrite}, 4'd0);
    NoWrite = 1'b0;
    #1;
    check("RegWrite", {3'b0, RegWrite}, 4'd1);

    write_flags(2'b11, 4'b0000);
    Cond = 4'h0;
    CondLatch = 1'b1;
    FlagW = 2'b11;
    ALUFlags = 4'b0100;
    step();
    CondLatch = 1'b0;
    FlagW = 2'b00;
    check("simul Flags", Flags, 4'b0100);
    check("simul CondEx", {3'b0, CondEx}, 4'd0);

    // Mid-instruction asynchronous reset
    latch(4'hE);
    #2;
    reset = 1'b0;
    #1;
    check("async Flags", Flags, 4'b0000);
    check("async strobes", {CondEx, PCWrite, RegWrite, MemWrite}, 4'b0000);
    step();
    reset = 1'b1;

    for (int i = 0; i < 600; i++) begin
      Cond = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW = 2'($urandom_range(0, 3));
      CondLatch = ($urandom_range(0, 3) == 0);
      PCS = 1'($urandom);
      RegW = 1'($urandom);
      MemW = 1'($urandom);
      NoWrite = 1'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
